// File: rtl/cpri_pattern_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpri_pattern_play_ctrl
// Function : frame-aligned, chip-grid-aligned playback sequencer for the
//            CPRI PRB test-pattern ROM bank (shared read address + valid)
// Revision : 1.0  initial release
// ============================================================================
module cpri_pattern_play_ctrl #(
  parameter int CHIP_LEN = 96,
  parameter int SOP_OFS  = 3,
  parameter int SYM_LEN  = 12672,
  parameter int ADDR_W   = 16,
  parameter int ROM_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aux_rx_rfp_rise,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [3:0]        cfg_sym_num,
  input  logic [7:0]        cfg_loops,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rden,
  output logic              vld_o,
  output logic              sop_o,
  output logic [3:0]        sym_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int c_chip_w = (CHIP_LEN > 1) ? $clog2(CHIP_LEN) : 1;
  localparam int c_word_w = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [c_chip_w-1:0] c_chip_last = c_chip_w'(CHIP_LEN - 1);
  localparam logic [c_chip_w-1:0] c_sop_ofs   = c_chip_w'(SOP_OFS);
  localparam logic [c_word_w-1:0] c_word_last = c_word_w'(SYM_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_ALIGN = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_chip_w-1:0] r_chip_cnt;
  logic [c_word_w-1:0] r_word_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic [3:0]          r_sym_num;
  logic [7:0]          r_loops;
  logic [7:0]          r_loop_cnt;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_rom_rden;
  logic [3:0]          r_sym;
  logic                r_done;
  logic                r_err;
  logic [ROM_LAT-1:0]  r_vld_pipe;

  logic                w_word_last;
  logic                w_pass_last;
  logic [7:0]          w_loop_next;
  logic                w_loops_done;
  logic                w_rfp_overrun;

  assign w_word_last   = (r_word_cnt == c_word_last);
  assign w_pass_last   = w_word_last && (r_sym == (r_sym_num - 4'd1));
  assign w_loop_next   = r_loop_cnt + 8'd1;
  assign w_loops_done  = (r_loops != 8'd0) && (w_loop_next == r_loops);
  assign w_rfp_overrun = aux_rx_rfp_rise && ((r_state == S_ALIGN) || (r_state == S_PLAY));

  // Free-running chip grid; never re-phased, playback aligns to it instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chip_cnt <= '0;
    end else if (r_chip_cnt == c_chip_last) begin
      r_chip_cnt <= '0;
    end else begin
      r_chip_cnt <= r_chip_cnt + c_chip_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_word_cnt <= '0;
      r_base     <= '0;
      r_sym_num  <= 4'd1;
      r_loops    <= 8'd0;
      r_loop_cnt <= 8'd0;
      r_rom_addr <= '0;
      r_rom_rden <= 1'b0;
      r_sym      <= 4'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_rfp_overrun;
      if (abort) begin
        r_state    <= S_IDLE;
        r_rom_rden <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_base     <= cfg_base_addr;
              r_sym_num  <= (cfg_sym_num == 4'd0) ? 4'd1 : cfg_sym_num;
              r_loops    <= cfg_loops;
              r_loop_cnt <= 8'd0;
              r_state    <= S_ARM;
            end
          end
          S_ARM: begin
            if (aux_rx_rfp_rise) begin
              r_state <= S_ALIGN;
            end
          end
          S_ALIGN: begin
            // Leaving on the last chip cycle puts the first read on chip 0.
            if (r_chip_cnt == c_chip_last) begin
              r_state    <= S_PLAY;
              r_rom_rden <= 1'b1;
              r_rom_addr <= r_base;
              r_sym      <= 4'd0;
              r_word_cnt <= '0;
            end
          end
          S_PLAY: begin
            if (w_pass_last) begin
              r_rom_rden <= 1'b0;
              r_loop_cnt <= w_loop_next;
              if (w_loops_done) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_ARM;
              end
            end else begin
              r_rom_addr <= r_rom_addr + ADDR_W'(1);
              if (w_word_last) begin
                r_word_cnt <= '0;
                r_sym      <= r_sym + 4'd1;
              end else begin
                r_word_cnt <= r_word_cnt + c_word_w'(1);
              end
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_rom_rden <= 1'b0;
          end
        endcase
      end
    end
  end

  // Delay line matching ROM read plus datapath output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_rom_rden;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign rom_rden = r_rom_rden;
  assign vld_o    = r_vld_pipe[ROM_LAT-1];
  assign sop_o    = (r_chip_cnt == c_sop_ofs);
  assign sym_o    = r_sym;
  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;
  assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpri_pattern_play_ctrl.sv
`default_nettype none
// Scoreboard bench for cpri_pattern_play_ctrl: expected ROM reads are queued
// when a pass is requested and matched against every rom_rden cycle.
module tb_cpri_pattern_play_ctrl;

  localparam int CHIP_LEN = 4;
  localparam int SOP_OFS  = 3;
  localparam int SYM_LEN  = 8;
  localparam int ADDR_W   = 16;
  localparam int ROM_LAT  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aux_rx_rfp_rise = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [3:0]        cfg_sym_num = 4'd0;
  logic [7:0]        cfg_loops = 8'd0;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rden;
  logic              vld_o;
  logic              sop_o;
  logic [3:0]        sym_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  always #5 clk = ~clk;

  cpri_pattern_play_ctrl #(
    .CHIP_LEN(CHIP_LEN), .SOP_OFS(SOP_OFS), .SYM_LEN(SYM_LEN),
    .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .aux_rx_rfp_rise(aux_rx_rfp_rise),
    .start(start), .abort(abort), .cfg_base_addr(cfg_base_addr),
    .cfg_sym_num(cfg_sym_num), .cfg_loops(cfg_loops),
    .rom_addr(rom_addr), .rom_rden(rom_rden), .vld_o(vld_o), .sop_o(sop_o),
    .sym_o(sym_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  sym;
    logic        first;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_done = 0;
  int   n_err = 0;
  int   tb_chip = 0;
  logic h1 = 1'b0;
  logic h2 = 1'b0;

  always @(posedge clk) tb_chip <= rst ? 0 : ((tb_chip == CHIP_LEN-1) ? 0 : tb_chip + 1);

  // Stream monitor: chip grid, vld delay, scoreboard of ROM reads, done timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      vectors++;
      if (sop_o !== (tb_chip == SOP_OFS)) begin
        miscompares++;
        $display("FAIL sop chip=%0d got %b exp %b", tb_chip, sop_o, (tb_chip == SOP_OFS));
      end
      vectors++;
      if (vld_o !== h2) begin
        miscompares++;
        $display("FAIL vld_delay t=%0t got %b exp %b", $time, vld_o, h2);
      end
      if (rom_rden === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rden_unexpected t=%0t got addr=%h exp no read", $time, rom_addr);
        end else begin
          e = q.pop_front();
          if (rom_addr !== e.addr || sym_o !== e.sym) begin
            miscompares++;
            $display("FAIL rom_read got addr=%h sym=%0d exp addr=%h sym=%0d",
                     rom_addr, sym_o, e.addr, e.sym);
          end
          if (e.first) begin
            vectors++;
            if (tb_chip != 0) begin
              miscompares++;
              $display("FAIL first_chip got chip=%0d exp 0", tb_chip);
            end
          end
        end
      end
      if (done_o === 1'b1) begin
        n_done++;
        vectors++;
        if (h1 !== 1'b1 || busy_o !== 1'b0) begin
          miscompares++;
          $display("FAIL done_timing got prev_rden=%b busy=%b exp 1/0", h1, busy_o);
        end
      end
      if (err_o === 1'b1) n_err++;
      h2 = h1;
      h1 = rom_rden;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] b, input logic [3:0] s, input logic [7:0] l);
    cfg_base_addr = b;
    cfg_sym_num   = s;
    cfg_loops     = l;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic pulse_rfp();
    aux_rx_rfp_rise = 1'b1;
    tick();
    aux_rx_rfp_rise = 1'b0;
  endtask

  task automatic push_words(input logic [15:0] b, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.addr  = b + 16'(i);
      e.sym   = 4'(i / SYM_LEN);
      e.first = (i == 0);
      q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (rom_addr !== 16'h0000 || rom_rden !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_addr got addr=%h rden=%b exp 0000/0", rom_addr, rom_rden);
    end
    vectors++;
    if (vld_o !== 1'b0 || sym_o !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_vld_sym got vld=%b sym=%0d exp 0/0", vld_o, sym_o);
    end
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status got busy=%b done=%b err=%b exp 0/0/0", busy_o, done_o, err_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pass();
    int c, d, got, n;
    n_done = 0;
    n_err  = 0;
    push_words(16'h0010, 16);
    do_start(16'h0010, 4'd2, 8'd1);
    repeat (3) tick();
    vectors++;
    if (busy_o !== 1'b1 || rom_rden !== 1'b0) begin
      miscompares++;
      $display("FAIL arm_hold got busy=%b rden=%b exp 1/0", busy_o, rom_rden);
    end
    c = tb_chip;
    d = (CHIP_LEN - ((c + 2) % CHIP_LEN)) % CHIP_LEN;
    pulse_rfp();
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      if (rom_rden === 1'b1) begin
        got = k;
        break;
      end
      tick();
    end
    vectors++;
    if (got != 2 + d) begin
      miscompares++;
      $display("FAIL first_read_latency got %0d exp %0d cycles after rfp", got, 2 + d);
    end
    n = 0;
    while (rom_rden === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    vectors++;
    if (n != 16) begin
      miscompares++;
      $display("FAIL burst_len got %0d exp 16", n);
    end
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL end_of_pass got busy=%b done=%b exp 0/1", busy_o, done_o);
    end
    repeat (4) tick();
    vectors++;
    if (q.size() != 0 || n_done != 1 || n_err != 0) begin
      miscompares++;
      $display("FAIL single_pass got left=%0d done=%0d err=%0d exp 0/1/0", q.size(), n_done, n_err);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    n_done = 0;
    push_words(16'hFFFC, 8);
    do_start(16'hFFFC, 4'd1, 8'd1);
    tick();
    pulse_rfp();
    wait_idle(60, ok);
    repeat (4) tick();
    vectors++;
    if (!ok || q.size() != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL addr_wrap got idle=%b left=%0d done=%0d exp 1/0/1", ok, q.size(), n_done);
    end
  endtask

  task automatic test_looping();
    n_done = 0;
    n_err  = 0;
    for (int p = 0; p < 3; p++) push_words(16'h0100, 8);
    do_start(16'h0100, 4'd1, 8'd3);
    for (int p = 0; p < 3; p++) begin
      pulse_rfp();
      repeat (39) tick();
      if (p < 2) begin
        vectors++;
        if (busy_o !== 1'b1 || n_done != 0) begin
          miscompares++;
          $display("FAIL loop_rearm pass=%0d got busy=%b done=%0d exp 1/0", p, busy_o, n_done);
        end
      end
    end
    vectors++;
    if (busy_o !== 1'b0 || q.size() != 0 || n_done != 1 || n_err != 0) begin
      miscompares++;
      $display("FAIL looping got busy=%b left=%0d done=%0d err=%0d exp 0/0/1/0",
               busy_o, q.size(), n_done, n_err);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    bit seen;
    n_done = 0;
    n_err  = 0;
    push_words(16'h0200, 16);
    do_start(16'h0200, 4'd2, 8'd1);
    tick();
    pulse_rfp();
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rom_rden === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    pulse_rfp();
    do_start(16'h0300, 4'd4, 8'd5);
    wait_idle(60, ok);
    repeat (4) tick();
    vectors++;
    if (!seen || !ok || q.size() != 0 || n_done != 1 || n_err != 1) begin
      miscompares++;
      $display("FAIL overrun got play=%b idle=%b left=%0d done=%0d err=%0d exp 1/1/0/1/1",
               seen, ok, q.size(), n_done, n_err);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit seen;
    n_done = 0;
    push_words(16'h0040, 6);
    do_start(16'h0040, 4'd2, 8'd1);
    tick();
    pulse_rfp();
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (rom_rden === 1'b1 && rom_addr === 16'h0045) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (!seen || rom_rden !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_stop got word5=%b rden=%b busy=%b exp 1/0/0", seen, rom_rden, busy_o);
    end
    repeat (6) tick();
    vectors++;
    if (n_done != 0 || q.size() != 0 || vld_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet got done=%0d left=%0d vld=%b exp 0/0/0", n_done, q.size(), vld_o);
    end
    push_words(16'h0040, 16);
    do_start(16'h0040, 4'd2, 8'd1);
    tick();
    pulse_rfp();
    wait_idle(60, ok);
    repeat (4) tick();
    vectors++;
    if (!ok || q.size() != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL abort_replay got idle=%b left=%0d done=%0d exp 1/0/1", ok, q.size(), n_done);
    end
  endtask

  task automatic test_reset_edges();
    bit ok;
    bit seen;
    n_done = 0;
    push_words(16'h0080, 8);
    do_start(16'h0080, 4'd1, 8'd1);
    tick();
    pulse_rfp();
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (rom_rden === 1'b1 && rom_addr === 16'h0083) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (!seen || rom_addr !== 16'h0000 || rom_rden !== 1'b0 || vld_o !== 1'b0 || sym_o !== 4'd0) begin
      miscompares++;
      $display("FAIL play_reset_data got play=%b addr=%h rden=%b vld=%b sym=%0d exp 1/0000/0/0/0",
               seen, rom_addr, rom_rden, vld_o, sym_o);
    end
    vectors++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || sop_o !== 1'b0) begin
      miscompares++;
      $display("FAIL play_reset_status got busy=%b done=%b err=%b sop=%b exp 0/0/0/0",
               busy_o, done_o, err_o, sop_o);
    end
    q.delete();
    rst = 1'b0;
    repeat (4) tick();
    vectors++;
    if (n_done != 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got done=%0d busy=%b exp 0/0", n_done, busy_o);
    end

    push_words(16'h0500, 8);
    do_start(16'h0500, 4'd0, 8'd1);
    tick();
    pulse_rfp();
    wait_idle(60, ok);
    repeat (4) tick();
    vectors++;
    if (!ok || q.size() != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL sym_num_zero got idle=%b left=%0d done=%0d exp 1/0/1", ok, q.size(), n_done);
    end

    n_done = 0;
    cfg_base_addr = 16'h0600;
    cfg_sym_num   = 4'd1;
    cfg_loops     = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_start_same got busy=%b exp 0", busy_o);
    end
    pulse_rfp();
    repeat (10) tick();
    vectors++;
    if (busy_o !== 1'b0 || n_done != 0) begin
      miscompares++;
      $display("FAIL abort_start_idle got busy=%b done=%0d exp 0/0", busy_o, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_addr_wrap();
    test_looping();
    test_overrun();
    test_abort();
    test_reset_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time=%0t exp completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
